// File: rtl/miriscv_opcodes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : miriscv_opcodes_pkg
// Description : Shared opcode constants for the miriscv decode path.
//               Holds the base-ISA major opcodes (instr[6:2]), the RVC
//               {funct3, op} keys and the immediate format code.
// Revision    : 1.1 - add imm_fmt_e and RVC immediate keys
// ============================================================================
package miriscv_opcodes_pkg;

  // Base ISA major opcodes, instr[6:2] (instr[1:0] == 2'b11)
  localparam logic [4:0] S_OPCODE_LOAD   = 5'b00000;
  localparam logic [4:0] S_OPCODE_MISCMEM = 5'b00011;
  localparam logic [4:0] S_OPCODE_OPIMM  = 5'b00100;
  localparam logic [4:0] S_OPCODE_AUIPC  = 5'b00101;
  localparam logic [4:0] S_OPCODE_STORE  = 5'b01000;
  localparam logic [4:0] S_OPCODE_OP     = 5'b01100;
  localparam logic [4:0] S_OPCODE_LUI    = 5'b01101;
  localparam logic [4:0] S_OPCODE_BRANCH = 5'b11000;
  localparam logic [4:0] S_OPCODE_JALR   = 5'b11001;
  localparam logic [4:0] S_OPCODE_JAL    = 5'b11011;
  localparam logic [4:0] S_OPCODE_SYSTEM = 5'b11100;

  // RVC keys: {funct3 = instr[15:13], op = instr[1:0]}
  localparam logic [4:0] S_RVC_ADDI4SPN = 5'b000_00;
  localparam logic [4:0] S_RVC_LW       = 5'b010_00;
  localparam logic [4:0] S_RVC_SW       = 5'b110_00;
  localparam logic [4:0] S_RVC_ADDI     = 5'b000_01;
  localparam logic [4:0] S_RVC_LI       = 5'b010_01;
  localparam logic [4:0] S_RVC_LUI      = 5'b011_01;
  localparam logic [4:0] S_RVC_J        = 5'b101_01;
  localparam logic [4:0] S_RVC_BEQZ     = 5'b110_01;
  localparam logic [4:0] S_RVC_BNEZ     = 5'b111_01;

  typedef enum logic [2:0] {
    IMM_FMT_NONE   = 3'd0,
    IMM_FMT_I      = 3'd1,
    IMM_FMT_S      = 3'd2,
    IMM_FMT_B      = 3'd3,
    IMM_FMT_U      = 3'd4,
    IMM_FMT_J      = 3'd5,
    IMM_FMT_C_SEXT = 3'd6,
    IMM_FMT_C_ZEXT = 3'd7
  } imm_fmt_e;

endpackage
`default_nettype wire

// File: rtl/miriscv_imm_decode.sv
`default_nettype none
// ============================================================================
// Module      : miriscv_imm_decode
// Description : Combinational immediate extraction for base (I/S/B/U/J) and
//               a subset of RVC formats. The immediate is assembled to 32
//               bits and then sign-extended from bit 31 to XLEN.
// Ports       : i_instr [31:0]   instruction (compressed in [15:0])
//               o_imm   [XLEN-1:0] extended immediate
//               o_fmt   imm_fmt_e  format code
// Revision    : 1.0 - initial release
// ============================================================================
module miriscv_imm_decode
  import miriscv_opcodes_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit RVC_EN = 1'b1
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm,
  output imm_fmt_e        o_fmt
);

  logic [31:0] w_imm32;
  logic [4:0]  w_rvc_key;

  assign w_rvc_key = {i_instr[15:13], i_instr[1:0]};

  always_comb begin
    w_imm32 = '0;
    o_fmt   = IMM_FMT_NONE;
    if (i_instr[1:0] == 2'b11) begin
      case (i_instr[6:2])
        S_OPCODE_OPIMM, S_OPCODE_LOAD, S_OPCODE_JALR: begin
          w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
          o_fmt   = IMM_FMT_I;
        end
        S_OPCODE_STORE: begin
          w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
          o_fmt   = IMM_FMT_S;
        end
        S_OPCODE_BRANCH: begin
          w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                     i_instr[30:25], i_instr[11:8], 1'b0};
          o_fmt   = IMM_FMT_B;
        end
        S_OPCODE_LUI, S_OPCODE_AUIPC: begin
          w_imm32 = {i_instr[31:12], 12'b0};
          o_fmt   = IMM_FMT_U;
        end
        S_OPCODE_JAL: begin
          w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                     i_instr[20], i_instr[30:21], 1'b0};
          o_fmt   = IMM_FMT_J;
        end
        default: ;
      endcase
    end else if (RVC_EN) begin
      case (w_rvc_key)
        S_RVC_ADDI4SPN: begin
          // nzuimm[5:4|9:6|2|3] in instr[12:5]
          w_imm32 = {22'b0, i_instr[10:7], i_instr[12:11], i_instr[5],
                     i_instr[6], 2'b00};
          o_fmt   = IMM_FMT_C_ZEXT;
        end
        S_RVC_LW, S_RVC_SW: begin
          // uimm[5:3] in [12:10], uimm[2] in [6], uimm[6] in [5]
          w_imm32 = {25'b0, i_instr[5], i_instr[12:10], i_instr[6], 2'b00};
          o_fmt   = IMM_FMT_C_ZEXT;
        end
        S_RVC_ADDI, S_RVC_LI: begin
          w_imm32 = {{26{i_instr[12]}}, i_instr[12], i_instr[6:2]};
          o_fmt   = IMM_FMT_C_SEXT;
        end
        S_RVC_LUI: begin
          w_imm32 = {{14{i_instr[12]}}, i_instr[12], i_instr[6:2], 12'b0};
          o_fmt   = IMM_FMT_C_SEXT;
        end
        S_RVC_J: begin
          // offset[11|4|9:8|10|6|7|3:1|5] in instr[12:2]
          w_imm32 = {{20{i_instr[12]}}, i_instr[12], i_instr[8],
                     i_instr[10:9], i_instr[6], i_instr[7], i_instr[2],
                     i_instr[11], i_instr[5:3], 1'b0};
          o_fmt   = IMM_FMT_C_SEXT;
        end
        S_RVC_BEQZ, S_RVC_BNEZ: begin
          // offset[8|4:3] in [12:10], offset[7:6|2:1|5] in [6:2]
          w_imm32 = {{23{i_instr[12]}}, i_instr[12], i_instr[6:5],
                     i_instr[2], i_instr[11:10], i_instr[4:3], 1'b0};
          o_fmt   = IMM_FMT_C_SEXT;
        end
        default: ;
      endcase
    end
  end

  assign o_imm = XLEN'($signed(w_imm32));

endmodule
`default_nettype wire

// File: rtl/miriscv_imm_stage.sv
`default_nettype none
// ============================================================================
// Module      : miriscv_imm_stage
// Description : Registered, handshaked immediate-generation stage with a
//               2-entry skid buffer (out + skd) and synchronous flush.
// Ports       : clk_i, rst_i (sync, active-high), flush_i
//               instr_i/instr_valid_i/instr_ready_o  upstream handshake
//               imm_o/imm_fmt_o/instr_o/valid_o/ready_i downstream
// Revision    : 1.0 - initial release
// ============================================================================
module miriscv_imm_stage
  import miriscv_opcodes_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit RVC_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic [31:0]     instr_i,
  input  logic            instr_valid_i,
  output logic            instr_ready_o,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      imm_fmt_o,
  output logic [31:0]     instr_o,
  output logic            valid_o,
  input  logic            ready_i
);

  logic [XLEN-1:0] w_dec_imm;
  imm_fmt_e        w_dec_fmt;

  logic            r_out_valid;
  logic [XLEN-1:0] r_out_imm;
  imm_fmt_e        r_out_fmt;
  logic [31:0]     r_out_instr;

  logic            r_skd_valid;
  logic [XLEN-1:0] r_skd_imm;
  imm_fmt_e        r_skd_fmt;
  logic [31:0]     r_skd_instr;

  logic w_accept;
  logic w_out_free;
  logic w_out_from_skd;
  logic w_out_load_new;
  logic w_skd_load;

  miriscv_imm_decode #(
    .XLEN   (XLEN),
    .RVC_EN (RVC_EN)
  ) u_decode (
    .i_instr (instr_i),
    .o_imm   (w_dec_imm),
    .o_fmt   (w_dec_fmt)
  );

  // Ready depends only on skd occupancy, so there is no path from ready_i.
  assign instr_ready_o  = !r_skd_valid;
  assign w_accept       = instr_valid_i && instr_ready_o;
  assign w_out_free     = !r_out_valid || ready_i;
  // A held skd entry always has priority over new input to keep order;
  // w_accept is already low whenever skd is occupied.
  assign w_out_from_skd = w_out_free && r_skd_valid;
  assign w_out_load_new = w_out_free && w_accept;
  assign w_skd_load     = !w_out_free && w_accept;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out_valid <= 1'b0;
      r_skd_valid <= 1'b0;
    end else if (flush_i) begin
      r_out_valid <= 1'b0;
      r_skd_valid <= 1'b0;
    end else begin
      if (w_out_free) begin
        r_out_valid <= r_skd_valid || w_accept;
      end
      if (w_out_from_skd) begin
        r_skd_valid <= 1'b0;
      end else if (w_skd_load) begin
        r_skd_valid <= 1'b1;
      end
    end
  end

  // Payload is not reset; outputs are masked by valid below.
  always_ff @(posedge clk_i) begin
    if (w_out_from_skd) begin
      r_out_imm   <= r_skd_imm;
      r_out_fmt   <= r_skd_fmt;
      r_out_instr <= r_skd_instr;
    end else if (w_out_load_new) begin
      r_out_imm   <= w_dec_imm;
      r_out_fmt   <= w_dec_fmt;
      r_out_instr <= instr_i;
    end
    if (w_skd_load) begin
      r_skd_imm   <= w_dec_imm;
      r_skd_fmt   <= w_dec_fmt;
      r_skd_instr <= instr_i;
    end
  end

  assign valid_o   = r_out_valid;
  assign imm_o     = r_out_valid ? r_out_imm   : '0;
  assign imm_fmt_o = r_out_valid ? r_out_fmt   : IMM_FMT_NONE;
  assign instr_o   = r_out_valid ? r_out_instr : '0;

endmodule
`default_nettype wire

// File: tb/tb_miriscv_imm_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_miriscv_imm_stage
// Description : Self-checking bench for miriscv_imm_stage. Three instances
//               (XLEN32/RVC, XLEN64/RVC, XLEN32/no-RVC) share one stimulus
//               stream; a 2-deep queue model tracks held entries.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_miriscv_imm_stage;

  logic clk = 1'b0;
  logic rst = 1'b0, flush = 1'b0, instr_valid = 1'b0, ready = 1'b1;
  logic [31:0] instr = '0;

  logic        a_rdy, a_valid;  logic [31:0] a_imm; logic [2:0] a_fmt; logic [31:0] a_instr;
  logic        b_rdy, b_valid;  logic [63:0] b_imm; logic [2:0] b_fmt; logic [31:0] b_instr;
  logic        n_rdy, n_valid;  logic [31:0] n_imm; logic [2:0] n_fmt; logic [31:0] n_instr;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] q[$];
  logic [31:0] got[$];
  logic [4:0]  ops [9] = '{5'd0, 5'd4, 5'd25, 5'd8, 5'd24, 5'd13, 5'd5, 5'd27, 5'd12};

  always #5 clk = ~clk;

  miriscv_imm_stage #(.XLEN(32), .RVC_EN(1'b1)) u_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .instr_i(instr),
    .instr_valid_i(instr_valid), .instr_ready_o(a_rdy), .imm_o(a_imm),
    .imm_fmt_o(a_fmt), .instr_o(a_instr), .valid_o(a_valid), .ready_i(ready));

  miriscv_imm_stage #(.XLEN(64), .RVC_EN(1'b1)) u_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .instr_i(instr),
    .instr_valid_i(instr_valid), .instr_ready_o(b_rdy), .imm_o(b_imm),
    .imm_fmt_o(b_fmt), .instr_o(b_instr), .valid_o(b_valid), .ready_i(ready));

  miriscv_imm_stage #(.XLEN(32), .RVC_EN(1'b0)) u_n (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .instr_i(instr),
    .instr_valid_i(instr_valid), .instr_ready_o(n_rdy), .imm_o(n_imm),
    .imm_fmt_o(n_fmt), .instr_o(n_instr), .valid_o(n_valid), .ready_i(ready));

  // Reference immediate from the ISA field definitions, as a 64-bit value.
  function automatic void ref_dec(input logic [31:0] x, input bit rvc,
                                  output logic [63:0] imm, output logic [2:0] fmt);
    logic [63:0] v;
    v = 0; fmt = 0;
    if (x[1:0] == 2'b11) begin
      case (x[6:2])
        5'd0, 5'd4, 5'd25: begin fmt = 1; v = longint'($signed(x[31:20])); end
        5'd8:  begin fmt = 2; v = longint'($signed({x[31:25], x[11:7]})); end
        5'd24: begin fmt = 3; v = longint'($signed({x[31], x[7], x[30:25], x[11:8], 1'b0})); end
        5'd13, 5'd5: begin fmt = 4; v = longint'($signed({x[31:12], 12'b0})); end
        5'd27: begin fmt = 5; v = longint'($signed({x[31], x[19:12], x[20], x[30:21], 1'b0})); end
        default: ;
      endcase
    end else if (rvc) begin
      case ({x[15:13], x[1:0]})
        5'b000_00: begin fmt = 7; v = x[12:11]*16 + x[10:7]*64 + x[6]*4 + x[5]*8; end
        5'b010_00, 5'b110_00: begin fmt = 7; v = x[12:10]*8 + x[6]*4 + x[5]*64; end
        5'b000_01, 5'b010_01: begin fmt = 6; v = x[6:2] - (x[12] ? 32 : 0); end
        5'b011_01: begin fmt = 6; v = (x[6:2] - (x[12] ? 64'd32 : 64'd0)) * 4096; end
        5'b101_01: begin
          fmt = 6;
          v = x[11]*16 + x[10:9]*256 + x[8]*1024 + x[7]*64 + x[6]*128
              + x[5:3]*2 + x[2]*32 - (x[12] ? 2048 : 0);
        end
        5'b110_01, 5'b111_01: begin
          fmt = 6;
          v = x[11:10]*8 + x[6:5]*64 + x[4:3]*2 + x[2]*32 - (x[12] ? 256 : 0);
        end
        default: ;
      endcase
    end
    imm = v;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 3))
      0: ;
      1, 2: begin x[1:0] = 2'b11; x[6:2] = ops[$urandom_range(0, 8)]; end
      default: x[1:0] = 2'($urandom_range(0, 2));
    endcase
    return x;
  endfunction

  // Advance one clock and update the queue model; stimulus is already driven.
  task automatic tick();
    bit acc, drn;
    acc = instr_valid && (q.size() < 2);
    drn = (q.size() != 0) && ready;
    if (a_valid && ready) got.push_back(a_instr);
    @(posedge clk);
    if (rst || flush) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(instr);
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; instr_valid = 1'b0; ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp += 6;
    if (a_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_valid: got %b exp 0", a_valid); end
    if (a_rdy !== 1'b1)    begin n_bad++; $display("FAIL reset_ready: got %b exp 1", a_rdy); end
    if (a_imm !== 32'h0)   begin n_bad++; $display("FAIL reset_imm: got %h exp 0", a_imm); end
    if (a_fmt !== 3'd0)    begin n_bad++; $display("FAIL reset_fmt: got %0d exp 0", a_fmt); end
    if (a_instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr: got %h exp 0", a_instr); end
    if (b_imm !== 64'h0)   begin n_bad++; $display("FAIL reset_imm64: got %h exp 0", b_imm); end
  endtask

  task automatic test_vectors();
    logic [31:0] vi  [6] = '{32'hFFF00093, 32'hFE000EE3, 32'h0080006F,
                             32'h12345037, 32'h80000037, 32'h0000557D};
    logic [63:0] v64 [6] = '{64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFC, 64'h8,
                             64'h12345000, 64'hFFFFFFFF_80000000, 64'hFFFFFFFF_FFFFFFFF};
    logic [2:0]  vf  [6] = '{3'd1, 3'd3, 3'd5, 3'd4, 3'd4, 3'd6};
    logic [63:0] e;
    logic [31:0] e_n;
    logic [2:0]  ef_n;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      ready = 1'b1; instr_valid = 1'b1; instr = vi[k];
      tick();
      instr_valid = 1'b0;
      e = v64[k];
      e_n  = (vi[k][1:0] == 2'b11) ? e[31:0] : 32'h0;
      ef_n = (vi[k][1:0] == 2'b11) ? vf[k] : 3'd0;
      n_cmp += 7;
      if (a_valid !== 1'b1)     begin n_bad++; $display("FAIL vec%0d_valid: got %b exp 1", k, a_valid); end
      if (a_imm !== e[31:0])    begin n_bad++; $display("FAIL vec%0d_imm32: got %h exp %h", k, a_imm, e[31:0]); end
      if (a_fmt !== vf[k])      begin n_bad++; $display("FAIL vec%0d_fmt32: got %0d exp %0d", k, a_fmt, vf[k]); end
      if (a_instr !== vi[k])    begin n_bad++; $display("FAIL vec%0d_instr: got %h exp %h", k, a_instr, vi[k]); end
      if (b_imm !== e)          begin n_bad++; $display("FAIL vec%0d_imm64: got %h exp %h", k, b_imm, e); end
      if (n_imm !== e_n)        begin n_bad++; $display("FAIL vec%0d_norvc_imm: got %h exp %h", k, n_imm, e_n); end
      if (n_fmt !== ef_n)       begin n_bad++; $display("FAIL vec%0d_norvc_fmt: got %0d exp %0d", k, n_fmt, ef_n); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] bp [4];
    for (int k = 0; k < 4; k++) bp[k] = {2'(k), 30'($urandom)};
    do_reset(); got.delete();
    instr_valid = 1'b1; instr = bp[0]; tick();
    ready = 1'b0; instr = bp[1]; tick();
    n_cmp++;
    if (a_rdy !== 1'b0) begin n_bad++; $display("FAIL bp_ready_fall: got %b exp 0", a_rdy); end
    instr = bp[2]; repeat (3) tick();
    n_cmp += 2;
    if (a_rdy !== 1'b0)    begin n_bad++; $display("FAIL bp_ready_hold: got %b exp 0", a_rdy); end
    if (a_instr !== bp[0]) begin n_bad++; $display("FAIL bp_out_stable: got %h exp %h", a_instr, bp[0]); end
    ready = 1'b1; tick();
    n_cmp += 2;
    if (a_rdy !== 1'b1)    begin n_bad++; $display("FAIL bp_ready_rise: got %b exp 1", a_rdy); end
    if (a_instr !== bp[1]) begin n_bad++; $display("FAIL bp_skd_to_out: got %h exp %h", a_instr, bp[1]); end
    tick();
    instr = bp[3]; tick();
    instr_valid = 1'b0; repeat (3) tick();
    n_cmp++;
    if (got.size() != 4) begin n_bad++; $display("FAIL bp_count: got %0d exp 4", got.size()); end
    else for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (got[k] !== bp[k]) begin n_bad++; $display("FAIL bp_order%0d: got %h exp %h", k, got[k], bp[k]); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] d;
    d = 32'h00A00513;
    do_reset(); got.delete();
    ready = 1'b0; instr_valid = 1'b1; instr = 32'h11111093; tick();
    instr = 32'h22222093; tick();
    n_cmp++;
    if (a_rdy !== 1'b0) begin n_bad++; $display("FAIL fl_full: got %b exp 0", a_rdy); end
    instr = 32'h33333093; flush = 1'b1; tick();
    flush = 1'b0; instr_valid = 1'b0;
    n_cmp += 3;
    if (a_valid !== 1'b0) begin n_bad++; $display("FAIL fl_valid: got %b exp 0", a_valid); end
    if (a_rdy !== 1'b1)   begin n_bad++; $display("FAIL fl_ready: got %b exp 1", a_rdy); end
    if (b_valid !== 1'b0) begin n_bad++; $display("FAIL fl_valid64: got %b exp 0", b_valid); end
    ready = 1'b1; repeat (4) tick();
    n_cmp++;
    if (got.size() != 0) begin n_bad++; $display("FAIL fl_leak: got %0d entries exp 0", got.size()); end
    instr_valid = 1'b1; instr = d; tick(); instr_valid = 1'b0;
    n_cmp += 2;
    if (a_instr !== d)           begin n_bad++; $display("FAIL fl_after_instr: got %h exp %h", a_instr, d); end
    if (a_imm !== 32'h0000000A)  begin n_bad++; $display("FAIL fl_after_imm: got %h exp 0000000a", a_imm); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    ready = 1'b0; instr_valid = 1'b1; instr = 32'hFFF00093; tick();
    instr_valid = 1'b0;
    n_cmp++;
    if (a_valid !== 1'b1) begin n_bad++; $display("FAIL rm_pre_valid: got %b exp 1", a_valid); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp += 5;
    if (a_valid !== 1'b0)  begin n_bad++; $display("FAIL rm_valid: got %b exp 0", a_valid); end
    if (a_imm !== 32'h0)   begin n_bad++; $display("FAIL rm_imm: got %h exp 0", a_imm); end
    if (a_fmt !== 3'd0)    begin n_bad++; $display("FAIL rm_fmt: got %0d exp 0", a_fmt); end
    if (a_rdy !== 1'b1)    begin n_bad++; $display("FAIL rm_ready: got %b exp 1", a_rdy); end
    if (a_instr !== 32'h0) begin n_bad++; $display("FAIL rm_instr: got %h exp 0", a_instr); end
    ready = 1'b1;
  endtask

  task automatic test_random();
    logic [63:0] ei;
    logic [2:0]  ef;
    logic        e_rdy, e_vld;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      instr_valid = ($urandom_range(0, 3) != 0);
      ready       = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 31) == 0);
      instr       = rand_instr();
      tick();
      e_rdy = (q.size() < 2);
      e_vld = (q.size() != 0);
      n_cmp += 4;
      if (a_rdy !== e_rdy)   begin n_bad++; $display("FAIL rnd_ready c%0d: got %b exp %b", c, a_rdy, e_rdy); end
      if (a_valid !== e_vld) begin n_bad++; $display("FAIL rnd_valid c%0d: got %b exp %b", c, a_valid, e_vld); end
      if ({b_rdy, b_valid} !== {e_rdy, e_vld}) begin
        n_bad++; $display("FAIL rnd_hs64 c%0d: got %b%b exp %b%b", c, b_rdy, b_valid, e_rdy, e_vld);
      end
      if ({n_rdy, n_valid} !== {e_rdy, e_vld}) begin
        n_bad++; $display("FAIL rnd_hsnorvc c%0d: got %b%b exp %b%b", c, n_rdy, n_valid, e_rdy, e_vld);
      end
      if (q.size() != 0) begin
        ref_dec(q[0], 1'b1, ei, ef);
        n_cmp += 6;
        if (a_instr !== q[0])  begin n_bad++; $display("FAIL rnd_instr c%0d: got %h exp %h", c, a_instr, q[0]); end
        if (b_instr !== q[0])  begin n_bad++; $display("FAIL rnd_instr64 c%0d: got %h exp %h", c, b_instr, q[0]); end
        if (a_imm !== ei[31:0]) begin n_bad++; $display("FAIL rnd_imm32 c%0d i=%h: got %h exp %h", c, q[0], a_imm, ei[31:0]); end
        if (a_fmt !== ef)      begin n_bad++; $display("FAIL rnd_fmt32 c%0d i=%h: got %0d exp %0d", c, q[0], a_fmt, ef); end
        if (b_imm !== ei)      begin n_bad++; $display("FAIL rnd_imm64 c%0d i=%h: got %h exp %h", c, q[0], b_imm, ei); end
        if (b_fmt !== ef)      begin n_bad++; $display("FAIL rnd_fmt64 c%0d i=%h: got %0d exp %0d", c, q[0], b_fmt, ef); end
        ref_dec(q[0], 1'b0, ei, ef);
        n_cmp += 3;
        if (n_imm !== ei[31:0]) begin n_bad++; $display("FAIL rnd_norvc_imm c%0d i=%h: got %h exp %h", c, q[0], n_imm, ei[31:0]); end
        if (n_fmt !== ef)       begin n_bad++; $display("FAIL rnd_norvc_fmt c%0d i=%h: got %0d exp %0d", c, q[0], n_fmt, ef); end
        if (n_instr !== q[0])   begin n_bad++; $display("FAIL rnd_norvc_instr c%0d: got %h exp %h", c, n_instr, q[0]); end
      end
    end
    flush = 1'b0; instr_valid = 1'b0; ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
